// File: rtl/phy_reset_seq_if.sv
// Signal bundle between the PHY reset sequencer and its environment.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface phy_reset_seq_if #(
  parameter int NUM_CH = 2
);
  logic              i_locked;
  logic [NUM_CH-1:0] i_sw_rst_req;
  logic              i_fault;
  logic [NUM_CH-1:0] o_phy_resetn;
  logic              o_all_ready;
  logic              o_busy;
  logic              o_usr_led;

  modport master (
    output i_locked, i_sw_rst_req, i_fault,
    input  o_phy_resetn, o_all_ready, o_busy, o_usr_led
  );

  modport slave (
    input  i_locked, i_sw_rst_req, i_fault,
    output o_phy_resetn, o_all_ready, o_busy, o_usr_led
  );
endinterface

// File: rtl/phy_reset_seq.sv
// PHY/SerDes reset sequencer: lock-qualified hold, staggered per-channel release, per-channel soft re-reset.
// Optional heartbeat LED is built only when PHY_RESET_SEQ_HEARTBEAT_EN is defined.
module phy_reset_seq #(
  parameter int NUM_CH         = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int HOLD_CYCLES    = 65535,
  parameter int STAGGER_CYCLES = 1000,
  parameter int LED_DIV_BIT    = 26
) (
  input  logic           clk,
  input  logic           arst_n,
  phy_reset_seq_if.slave bus
);

  localparam int                   IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST   = CNT_WIDTH'((STAGGER_CYCLES > 0) ? (STAGGER_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE     = IDX_W'(1);
  localparam bit                   ALL_AT_ONCE = (NUM_CH == 1) || (STAGGER_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_STAGGER   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic                 r_lock_meta;
  logic                 r_locked_s;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [NUM_CH-1:0]    r_phy_resetn;
  logic [NUM_CH-1:0]    w_resetn_nxt;
  logic [NUM_CH-1:0]    r_sw_hold;
  logic [NUM_CH-1:0]    w_sw_hold_nxt;
  logic [CNT_WIDTH-1:0] r_sw_cnt [NUM_CH];
  logic [CNT_WIDTH-1:0] w_sw_cnt_nxt [NUM_CH];
  logic                 r_all_ready;
  logic                 w_ready_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_lock_meta <= bus.i_locked;
      r_locked_s  <= r_lock_meta;
    end
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_phy_resetn <= '0;
      r_sw_hold    <= '0;
      r_sw_cnt     <= '{default: '0};
      r_all_ready  <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_phy_resetn <= w_resetn_nxt;
      r_sw_hold    <= w_sw_hold_nxt;
      r_sw_cnt     <= w_sw_cnt_nxt;
      r_all_ready  <= w_ready_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and output decode; counters stop at their terminal value, so they cannot wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_resetn_nxt  = r_phy_resetn;
    w_sw_hold_nxt = r_sw_hold;
    w_sw_cnt_nxt  = r_sw_cnt;
    if (!r_locked_s) begin
      w_state_nxt   = ST_WAIT_LOCK;
      w_cnt_nxt     = '0;
      w_idx_nxt     = '0;
      w_resetn_nxt  = '0;
      w_sw_hold_nxt = '0;
      w_sw_cnt_nxt  = '{default: '0};
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_state_nxt  = ST_HOLD;
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_resetn_nxt = '0;
        end
        ST_HOLD: begin
          w_resetn_nxt = '0;
          if (r_cnt >= HOLD_LAST) begin
            w_cnt_nxt = '0;
            if (ALL_AT_ONCE) begin
              w_resetn_nxt = '1;
              w_state_nxt  = ST_RUN;
            end else begin
              w_resetn_nxt[0] = 1'b1;
              w_idx_nxt       = IDX_ONE;
              w_state_nxt     = ST_STAGGER;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_STAGGER: begin
          if (r_cnt >= STAG_LAST) begin
            w_cnt_nxt           = '0;
            w_resetn_nxt[r_idx] = 1'b1;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_idx_nxt = r_idx + IDX_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          // A request always (re)starts its channel's hold from zero.
          for (int k = 0; k < NUM_CH; k++) begin
            if (bus.i_sw_rst_req[k]) begin
              w_sw_hold_nxt[k] = 1'b1;
              w_sw_cnt_nxt[k]  = '0;
              w_resetn_nxt[k]  = 1'b0;
            end else if (r_sw_hold[k]) begin
              if (r_sw_cnt[k] >= HOLD_LAST) begin
                w_sw_hold_nxt[k] = 1'b0;
                w_resetn_nxt[k]  = 1'b1;
              end else begin
                w_sw_cnt_nxt[k] = r_sw_cnt[k] + CNT_ONE;
              end
            end else begin
              w_resetn_nxt[k] = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt  = ST_WAIT_LOCK;
          w_resetn_nxt = '0;
        end
      endcase
    end
    w_ready_nxt = (w_state_nxt == ST_RUN) && (&w_resetn_nxt);
    w_busy_nxt  = (w_state_nxt != ST_RUN) || (|w_sw_hold_nxt);
  end

  assign bus.o_phy_resetn = r_phy_resetn;
  assign bus.o_all_ready  = r_all_ready;
  assign bus.o_busy       = r_busy;

`ifdef PHY_RESET_SEQ_HEARTBEAT_EN
  localparam int HB_W = LED_DIV_BIT + 1;

  logic [HB_W-1:0] r_hb_cnt;
  logic            r_usr_led;
  logic            w_led_nxt;

  // LED source: fault solid, ready slow blink, otherwise fast blink.
  always_comb begin
    w_led_nxt = 1'b0;
    if (bus.i_fault) begin
      w_led_nxt = 1'b1;
    end else if (r_all_ready) begin
      w_led_nxt = r_hb_cnt[LED_DIV_BIT];
    end else begin
      w_led_nxt = r_hb_cnt[LED_DIV_BIT-3];
    end
  end

  // Free-running heartbeat divider and registered LED.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_hb_cnt  <= '0;
      r_usr_led <= 1'b0;
    end else begin
      r_hb_cnt  <= r_hb_cnt + HB_W'(1);
      r_usr_led <= w_led_nxt;
    end
  end

  assign bus.o_usr_led = r_usr_led;
`else
  logic w_unused_fault;

  assign w_unused_fault = bus.i_fault;
  assign bus.o_usr_led  = 1'b0;
`endif

endmodule

// File: tb/tb_phy_reset_seq.sv
// Scoreboard bench for phy_reset_seq: expected per-cycle outputs are queued with the stimulus
// and compared on the falling edge; heartbeat checks follow PHY_RESET_SEQ_HEARTBEAT_EN.
module tb_phy_reset_seq;

  localparam int NUM_CH = 2;
  localparam int HOLD   = 16;
  localparam int STAG   = 4;

  typedef struct {
    int         cyc;
    logic [1:0] resetn;
    logic       ready;
    logic       busy;
  } exp_t;

  logic clk;
  logic arst_n;
  int   cyc;
  int   n_total;
  int   n_bad;
  exp_t sb_q[$];
  exp_t mon_e;

  phy_reset_seq_if #(.NUM_CH(NUM_CH)) bus ();

  phy_reset_seq #(
    .NUM_CH        (NUM_CH),
    .CNT_WIDTH     (16),
    .HOLD_CYCLES   (HOLD),
    .STAGGER_CYCLES(STAG),
    .LED_DIV_BIT   (4)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [1:0] rn, input logic rdy, input logic bsy);
    exp_t e;
    e.cyc    = c;
    e.resetn = rn;
    e.ready  = rdy;
    e.busy   = bsy;
    sb_q.push_back(e);
  endtask

  // Full sequence with lock visible to the FSM at HOLD entry cycle t0.
  task automatic push_seq(input int c_from, input int c_to, input int t0);
    for (int c = c_from; c <= c_to; c++) begin
      push_exp(c, {c >= t0 + HOLD + STAG, c >= t0 + HOLD},
               c >= t0 + HOLD + STAG, c < t0 + HOLD + STAG);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [1:0] req);
    bus.i_sw_rst_req = req;
    @(negedge clk);
    bus.i_sw_rst_req = 2'b00;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk_eq("sb_drain", sb_q.size(), 32'd0);
  endtask

  task automatic meas_period(output int per);
    int   first;
    logic prev;
    per   = -1;
    first = -1;
    prev  = bus.o_usr_led;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_usr_led && !prev) begin
        if (first < 0) begin
          first = i;
        end else begin
          per = i - first;
          break;
        end
      end
      prev = bus.o_usr_led;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_resetn"}, bus.o_phy_resetn, 32'd0);
    chk_eq({tag, "_ready"},  bus.o_all_ready, 32'd0);
    chk_eq({tag, "_busy"},   bus.o_busy, 32'd1);
    chk_eq({tag, "_led"},    bus.o_usr_led, 32'd0);
  endtask

  // Scoreboard monitor: compare entries due this cycle, flag any that were skipped.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        chk_eq("sb_stale", mon_e.cyc, cyc);
      end else begin
        chk_eq("resetn", bus.o_phy_resetn, mon_e.resetn);
        chk_eq("ready",  bus.o_all_ready,  mon_e.ready);
        chk_eq("busy",   bus.o_busy,       mon_e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    int s;
    int d;
    int r;
    int per;
    n_total = 0;
    n_bad   = 0;
    arst_n           = 1'b0;
    bus.i_locked     = 1'b1;
    bus.i_sw_rst_req = 2'b00;
    bus.i_fault      = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");

    // Power-up; requests during HOLD and STAGGER must be ignored.
    b = cyc;
    push_seq(b + 1, b + 30, b + 3);
    arst_n = 1'b1;
    wait_cyc(b + 10);
    pulse_req(2'b11);
    wait_cyc(b + 21);
    pulse_req(2'b10);
    drain();

`ifdef PHY_RESET_SEQ_HEARTBEAT_EN
    meas_period(per);
    chk_eq("led_ready_period", per, 32'd32);
`else
    chk_eq("led_off_run", bus.o_usr_led, 32'd0);
`endif

    // Software reset of channel 1 only.
    s = cyc;
    for (int c = s + 1; c <= s + 20; c++) begin
      if (c <= s + HOLD) push_exp(c, 2'b01, 1'b0, 1'b1);
      else               push_exp(c, 2'b11, 1'b1, 1'b0);
    end
    pulse_req(2'b10);
    drain();

    // Simultaneous requests, then restart of channel 0 eight cycles later.
    s = cyc;
    for (int c = s + 1; c <= s + 28; c++) begin
      logic [1:0] rn;
      rn[0] = !(c >= s + 1 && c <= s + 24);
      rn[1] = !(c >= s + 1 && c <= s + 16);
      push_exp(c, rn, &rn, !(&rn));
    end
    pulse_req(2'b11);
    wait_cyc(s + 8);
    pulse_req(2'b01);
    drain();

    // Fault LED.
    bus.i_fault = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
`ifdef PHY_RESET_SEQ_HEARTBEAT_EN
      chk_eq("led_fault", bus.o_usr_led, 32'd1);
`else
      chk_eq("led_fault_off", bus.o_usr_led, 32'd0);
`endif
      @(negedge clk);
    end
    bus.i_fault = 1'b0;

    // Asynchronous reset in RUN, checked between clock edges.
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_vals("arst_run");
    repeat (2) @(negedge clk);

    // Restart from reset, lose lock in STAGGER, relock and replay.
    b = cyc;
    push_seq(b + 1, b + 20, b + 3);
    arst_n = 1'b1;
    wait_cyc(b + 20);
    d = cyc;
    r = d + 6;
    push_seq(d + 3, r + 25, r + 3);
    bus.i_locked = 1'b0;
    wait_cyc(r);
    bus.i_locked = 1'b1;
    drain();

    // LED while not ready.
    bus.i_locked = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq("unlock_resetn", bus.o_phy_resetn, 32'd0);
`ifdef PHY_RESET_SEQ_HEARTBEAT_EN
    meas_period(per);
    chk_eq("led_busy_period", per, 32'd4);
`else
    chk_eq("led_off_unlocked", bus.o_usr_led, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
